agc_loop_ctrl: RTL and testbench

//   Closed-loop gain controller for agc_top. Measures |I|+|Q| of agc_top's Q8.8

---
 rtl/agc_loop_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_agc_loop_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/agc_loop_ctrl.sv
// agc_loop_ctrl
//   Closed-loop gain controller for agc_top. Sums |I|+|Q| of the Q8.8 samples
//   coming back from agc_top over windows of 2^WIN_LOG2 samples, compares the
//   window mean with TARGET and steps an unsigned Q8.8 gain word. A small FSM
//   sequences IDLE / ACQUIRE / TRACK / HOLD and reports lock.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   en           in   1   loop enable; low forces IDLE
//   freeze       in   1   hold gain (HOLD) while high
//   sample_valid in   1   z_i_in / z_q_in valid this cycle
//   z_i_in       in   16  signed Q8.8 in-phase sample
//   z_q_in       in   16  signed Q8.8 quadrature sample
//   gain_out     out  16  unsigned Q8.8 gain
//   gain_valid   out  1   one-cycle pulse when gain_out is updated
//   locked       out  1   loop locked
//   state_out    out  2   00 IDLE, 01 ACQUIRE, 10 TRACK, 11 HOLD
module agc_loop_ctrl #(
  parameter int                DATA_W     = 16,
  parameter int                WIN_LOG2   = 4,
  parameter logic [DATA_W-1:0] TARGET     = 16'h0200,
  parameter logic [DATA_W-1:0] GAIN_INIT  = 16'h0100,
  parameter logic [DATA_W-1:0] GAIN_MIN   = 16'h0010,
  parameter logic [DATA_W-1:0] GAIN_MAX   = 16'h1000,
  parameter int                MU_SHIFT   = 2,
  parameter logic [DATA_W-1:0] LOCK_TOL   = 16'h0020,
  parameter logic [DATA_W-1:0] UNLOCK_TOL = 16'h0080,
  parameter int                LOCK_CNT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              freeze,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] z_i_in,
  input  logic [DATA_W-1:0] z_q_in,
  output logic [DATA_W-1:0] gain_out,
  output logic              gain_valid,
  output logic              locked,
  output logic [1:0]        state_out
);

  localparam int MAG_W = DATA_W + 1;
  localparam int ACC_W = MAG_W + WIN_LOG2;
  localparam int ERR_W = DATA_W + 2;
  localparam int LC_W  = $clog2(LOCK_CNT + 1);
  localparam logic [LC_W-1:0] LOCK_CNT_V = LC_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ACQUIRE = 2'b01,
    S_TRACK   = 2'b10,
    S_HOLD    = 2'b11
  } state_t;

  // |x| computed one bit wider so -32768 maps to +32768 without wrapping.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [DATA_W-1:0] x);
    logic signed [MAG_W-1:0] xe;
    xe = $signed({x[DATA_W-1], x});
    return (xe < 0) ? $unsigned(-xe) : $unsigned(xe);
  endfunction

  function automatic logic [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] e);
    return (e < 0) ? $unsigned(-e) : $unsigned(e);
  endfunction

  // Clamp a widened signed gain sum into [GAIN_MIN, GAIN_MAX].
  function automatic logic [DATA_W-1:0] sat_gain(input logic signed [ERR_W:0] g);
    logic signed [ERR_W:0] gmin;
    logic signed [ERR_W:0] gmax;
    gmin = $signed({{(ERR_W+1-DATA_W){1'b0}}, GAIN_MIN});
    gmax = $signed({{(ERR_W+1-DATA_W){1'b0}}, GAIN_MAX});
    if (g < gmin)      return GAIN_MIN;
    else if (g > gmax) return GAIN_MAX;
    else               return g[DATA_W-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     gain_p1, gain_d;
  logic                  vld_p1, vld_d;
  logic                  locked_q, locked_d;
  logic [ACC_W-1:0]      acc_p1, acc_d;
  logic [WIN_LOG2-1:0]   cnt_p1, cnt_d;
  logic [LC_W-1:0]       lcnt_q, lcnt_d;

  logic [MAG_W-1:0]         mag_p0;
  logic [ACC_W-1:0]         acc_sum_p0;
  logic [MAG_W-1:0]         avg_p0;
  logic signed [ERR_W-1:0]  err_p0;
  logic [ERR_W-1:0]         err_abs_p0;
  logic signed [ERR_W-1:0]  step_p0;
  logic signed [ERR_W:0]    gain_sum_p0;
  logic                     last_p0;
  logic                     in_tol_p0;
  logic [LC_W-1:0]          lcnt_inc_p0;

  // Stage p0: combinational measurement of the sample and, on the last sample
  // of a window, the error and candidate gain.
  always_comb begin
    mag_p0      = abs_mag(z_i_in) + abs_mag(z_q_in);
    acc_sum_p0  = acc_p1 + ACC_W'(mag_p0);
    avg_p0      = acc_sum_p0[ACC_W-1:WIN_LOG2];
    err_p0      = $signed({2'b00, TARGET}) - $signed({1'b0, avg_p0});
    err_abs_p0  = abs_err(err_p0);
    // TRACK uses a finer step than ACQUIRE.
    step_p0     = (state_q == S_TRACK) ? (err_p0 >>> (MU_SHIFT + 2))
                                       : (err_p0 >>> MU_SHIFT);
    gain_sum_p0 = $signed({{(ERR_W+1-DATA_W){1'b0}}, gain_p1})
                + $signed({step_p0[ERR_W-1], step_p0});
    last_p0     = sample_valid && (cnt_p1 == {WIN_LOG2{1'b1}});
    in_tol_p0   = (err_abs_p0 <= {2'b00, LOCK_TOL});
    lcnt_inc_p0 = (lcnt_q == LOCK_CNT_V) ? lcnt_q : (lcnt_q + 1'b1);
  end

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_p1;
    vld_d    = 1'b0;
    locked_d = locked_q;
    acc_d    = acc_p1;
    cnt_d    = cnt_p1;
    lcnt_d   = lcnt_q;

    if (!en) begin
      // Disable wins over everything, including a completing window.
      state_d  = S_IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      lcnt_d   = '0;
      locked_d = 1'b0;
    end else if (freeze) begin
      // Freeze discards the partial window and suppresses a coinciding update.
      state_d = S_HOLD;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ACQUIRE;
        end
        S_HOLD: begin
          state_d = locked_q ? S_TRACK : S_ACQUIRE;
        end
        default: begin
          if (sample_valid) begin
            if (last_p0) begin
              acc_d  = '0;
              cnt_d  = '0;
              vld_d  = 1'b1;
              gain_d = sat_gain(gain_sum_p0);
              lcnt_d = in_tol_p0 ? lcnt_inc_p0 : '0;
              if (state_q == S_ACQUIRE) begin
                if (in_tol_p0 && (lcnt_inc_p0 == LOCK_CNT_V)) begin
                  state_d  = S_TRACK;
                  locked_d = 1'b1;
                end
              end else if (err_abs_p0 > {2'b00, UNLOCK_TOL}) begin
                state_d  = S_ACQUIRE;
                locked_d = 1'b0;
                lcnt_d   = '0;
              end
            end else begin
              acc_d = acc_sum_p0;
              cnt_d = cnt_p1 + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Stage p1: registered loop state, accumulator and gain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gain_p1  <= GAIN_INIT;
      vld_p1   <= 1'b0;
      locked_q <= 1'b0;
      acc_p1   <= '0;
      cnt_p1   <= '0;
      lcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      gain_p1  <= gain_d;
      vld_p1   <= vld_d;
      locked_q <= locked_d;
      acc_p1   <= acc_d;
      cnt_p1   <= cnt_d;
      lcnt_q   <= lcnt_d;
    end
  end

  assign gain_out   = gain_p1;
  assign gain_valid = vld_p1;
  assign locked     = locked_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Directed bench for agc_loop_ctrl: reset values, window update, gain
// saturation at both clamps, lock/unlock, freeze/HOLD, en drop and async reset.
module tb_agc_loop_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        freeze = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] z_i_in = '0;
  logic [15:0] z_q_in = '0;
  logic [15:0] gain_out;
  logic        gain_valid;
  logic        locked;
  logic [1:0]  state_out;

  int total = 0;
  int bad   = 0;

  agc_loop_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .freeze       (freeze),
    .sample_valid (sample_valid),
    .z_i_in       (z_i_in),
    .z_q_in       (z_q_in),
    .gain_out     (gain_out),
    .gain_valid   (gain_valid),
    .locked       (locked),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then settle just past the rising edge.
  task automatic smp(input logic [15:0] i, input logic [15:0] q, input logic v);
    @(negedge clk);
    z_i_in = i;
    z_q_in = q;
    sample_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic win(input logic [15:0] i, input logic [15:0] q);
    for (int k = 0; k < 16; k++) smp(i, q, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    freeze = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset, enable, and spend the IDLE->ACQUIRE cycle.
  task automatic start();
    do_reset();
    en = 1'b1;
    smp(16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    // Reset values while rst is held
    @(posedge clk);
    #1;
    chk("rst_gain", gain_out, 16'h0100);
    chk("rst_vld", gain_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_state", state_out, 2'b00);

    // 1: single window, err=+0x100, ACQUIRE step 0x100>>>2=0x40
    start();
    chk("t1_state_acq", state_out, 2'b01);
    for (int k = 0; k < 15; k++) smp(16'h0100, 16'h0000, 1'b1);
    chk("t1_no_vld_early", gain_valid, 1'b0);
    chk("t1_gain_early", gain_out, 16'h0100);
    smp(16'h0100, 16'h0000, 1'b1);
    chk("t1_vld", gain_valid, 1'b1);
    chk("t1_gain", gain_out, 16'h0140);
    smp(16'h0, 16'h0, 1'b0);
    chk("t1_vld_drop", gain_valid, 1'b0);
    chk("t1_gain_hold", gain_out, 16'h0140);

    // 2: zero input, +0x80 per window, hits 0x1000 after 30 windows, then clamps
    start();
    for (int w = 1; w <= 30; w++) begin
      win(16'h0, 16'h0);
      chk("t2_step", gain_out, 16'h0100 + 16'(w * 16'h0080));
    end
    win(16'h0, 16'h0);
    chk("t2_sat_vld", gain_valid, 1'b1);
    chk("t2_sat_gain", gain_out, 16'h1000);
    win(16'h0, 16'h0);
    chk("t2_sat_gain2", gain_out, 16'h1000);

    // 3: on-target windows lock after the 4th; then err=-0x200 unlocks, step -0x20
    start();
    for (int w = 1; w <= 3; w++) begin
      win(16'h0100, 16'h0100);
      chk("t3_not_locked", locked, 1'b0);
    end
    win(16'h0100, 16'h0100);
    chk("t3_locked", locked, 1'b1);
    chk("t3_state_trk", state_out, 2'b10);
    chk("t3_gain_same", gain_out, 16'h0100);
    win(16'h0400, 16'h0000);
    chk("t3_unlocked", locked, 1'b0);
    chk("t3_state_acq", state_out, 2'b01);
    chk("t3_gain_drop", gain_out, 16'h00E0);

    // 4: full-scale negative samples, mag=65536, gain clamps at 0x0010
    start();
    win(16'h8000, 16'h8000);
    chk("t4_vld", gain_valid, 1'b1);
    chk("t4_gain_min", gain_out, 16'h0010);
    win(16'h8000, 16'h8000);
    chk("t4_gain_min2", gain_out, 16'h0010);
    chk("t4_state", state_out, 2'b01);

    // 5: freeze after sample 10, then 16 fresh samples needed
    start();
    for (int k = 0; k < 10; k++) smp(16'h0, 16'h0, 1'b1);
    freeze = 1'b1;
    smp(16'h0, 16'h0, 1'b1);
    chk("t5_hold", state_out, 2'b11);
    chk("t5_hold_vld", gain_valid, 1'b0);
    for (int k = 0; k < 8; k++) smp(16'h0, 16'h0, 1'b1);
    chk("t5_hold_novld", gain_valid, 1'b0);
    chk("t5_hold_gain", gain_out, 16'h0100);
    freeze = 1'b0;
    smp(16'h0, 16'h0, 1'b0);
    chk("t5_resume", state_out, 2'b01);
    for (int k = 0; k < 15; k++) smp(16'h0, 16'h0, 1'b1);
    chk("t5_15_novld", gain_valid, 1'b0);
    chk("t5_15_gain", gain_out, 16'h0100);
    smp(16'h0, 16'h0, 1'b1);
    chk("t5_16_vld", gain_valid, 1'b1);
    chk("t5_16_gain", gain_out, 16'h0180);

    // en falls on the last sample of a window: no update, IDLE
    start();
    for (int k = 0; k < 15; k++) smp(16'h0, 16'h0, 1'b1);
    en = 1'b0;
    smp(16'h0, 16'h0, 1'b1);
    chk("en_drop_vld", gain_valid, 1'b0);
    chk("en_drop_gain", gain_out, 16'h0100);
    chk("en_drop_state", state_out, 2'b00);

    // 6: lock, nudge gain in TRACK (err=-8 -> -1), then async reset mid-window
    start();
    for (int w = 0; w < 4; w++) win(16'h0100, 16'h0100);
    win(16'h0108, 16'h0100);
    chk("t6_trk_gain", gain_out, 16'h00FF);
    chk("t6_trk_state", state_out, 2'b10);
    chk("t6_trk_locked", locked, 1'b1);
    for (int k = 0; k < 5; k++) smp(16'h0100, 16'h0100, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_gain", gain_out, 16'h0100);
    chk("t6_rst_locked", locked, 1'b0);
    chk("t6_rst_state", state_out, 2'b00);
    chk("t6_rst_vld", gain_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
